commit_trace_buffer: RTL and testbench

- Sits directly downstream of core_model's commit port (pc_o, instr_o, reg_addr_o, reg_data_o, update_o).
- Captures every retirement record into a show-ahead FIFO and presents the records to a trace consumer (logger, checker or DMA) over a valid/ready handshake.
- Keeps retire and drop counters plus a sticky overflow flag, so a slow consumer never stalls the core and lost records are always accounted for.

---
 rtl/commit_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Captures every retirement record coming off the core's commit port into a
// show-ahead FIFO and presents the records to a trace consumer over a
// valid/ready handshake. The core is never stalled. When the FIFO is full and
// the consumer does not pop, the incoming record is dropped. Each drop is
// counted in a saturating counter and latched in a sticky overflow flag.
//
// Parameters
//   XLEN   width of pc, instruction word and register data (RV32 core: 32)
//   DEPTH  FIFO entries, power of two, >= 2
//   CNT_W  width of the retire and drop counters
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   update_i         core retired one instruction this cycle
//   pc_i             pc of the retired instruction
//   instr_i          instruction word
//   reg_addr_i       destination register (0 = no writeback)
//   reg_data_i       writeback value
//   clr_i            flush FIFO, clear counters and overflow
//   trace_valid_o    head record available
//   trace_ready_i    consumer accepts head record
//   trace_pc_o       head record pc
//   trace_instr_o    head record instruction
//   trace_rd_o       head record destination register
//   trace_rd_data_o  head record data (0 when rd == 0)
//   trace_wb_o       head record wrote a register
//   level_o          current occupancy
//   retire_cnt_o     update_i pulses seen, wraps
//   drop_cnt_o       records lost to a full FIFO, saturates
//   overflow_o       sticky, set on the first drop
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     clr_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [4:0]               trace_rd_o,
  output logic [XLEN-1:0]          trace_rd_data_o,
  output logic                     trace_wb_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         retire_cnt_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned REC_W = 3 * XLEN + 5;

  // Record layout: {pc, instr, rd, rd_data}
  localparam int unsigned PC_HI    = REC_W - 1;
  localparam int unsigned INSTR_HI = 2 * XLEN + 4;
  localparam int unsigned RD_HI    = XLEN + 4;

  logic [REC_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic             empty, full, valid;
  logic             push, pop, drop;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] head_rec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign valid = !empty;

  assign pop  = valid && trace_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = update_i && (!full || pop);
  assign drop = update_i && full && !pop;

  // x0 writes carry no data; normalise before storing.
  assign wr_rec = {pc_i, instr_i, reg_addr_i,
                   (reg_addr_i == 5'd0) ? {XLEN{1'b0}} : reg_data_i};

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    retire_d = retire_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push)     wptr_d   = wptr_q + PW'(1);
    if (pop)      rptr_d   = rptr_q + PW'(1);
    if (update_i) retire_d = retire_q + CNT_W'(1);
    if (drop) begin
      drop_d = sat_inc(drop_q);
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      retire_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale contents are masked by the valid gate below.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i && !clr_i) begin
      mem_q[wptr_q[AW-1:0]] <= wr_rec;
    end
  end

  // Show-ahead read of the head entry, forced to zero while empty.
  assign head_rec = valid ? mem_q[rptr_q[AW-1:0]] : '0;

  assign trace_valid_o   = valid;
  assign trace_pc_o      = head_rec[PC_HI -: XLEN];
  assign trace_instr_o   = head_rec[INSTR_HI -: XLEN];
  assign trace_rd_o      = head_rec[RD_HI -: 5];
  assign trace_rd_data_o = head_rec[XLEN-1:0];
  assign trace_wb_o      = (head_rec[RD_HI -: 5] != 5'd0);

  assign level_o      = wptr_q - rptr_q;
  assign retire_cnt_o = retire_q;
  assign drop_cnt_o   = drop_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic              clk;
  logic              rst;
  logic              update;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   instr;
  logic [4:0]        reg_addr;
  logic [XLEN-1:0]   reg_data;
  logic              clr;
  logic              t_valid;
  logic              t_ready;
  logic [XLEN-1:0]   t_pc;
  logic [XLEN-1:0]   t_instr;
  logic [4:0]        t_rd;
  logic [XLEN-1:0]   t_rd_data;
  logic              t_wb;
  logic [4:0]        level;
  logic [CNT_W-1:0]  retire_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              overflow;

  int tests;
  int fails;
  int exp_retire;
  int exp_drop;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(reg_addr), .reg_data_i(reg_data), .clr_i(clr),
    .trace_valid_o(t_valid), .trace_ready_i(t_ready), .trace_pc_o(t_pc),
    .trace_instr_o(t_instr), .trace_rd_o(t_rd), .trace_rd_data_o(t_rd_data),
    .trace_wb_o(t_wb), .level_o(level), .retire_cnt_o(retire_cnt),
    .drop_cnt_o(drop_cnt), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; update = 1'b1; pc = 32'h1234; instr = 32'h13; reg_addr = 5'd3;
    reg_data = 32'h55; t_ready = 1'b0; clr = 1'b0;
    step(); step();
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", t_valid); end
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
    tests++; if (t_pc !== 32'd0) begin fails++; $display("FAIL reset_pc got %h want 0", t_pc); end
    rst = 1'b0;
    pc = 32'h8000_0000; instr = 32'h0000_0093; reg_addr = 5'd1; reg_data = 32'h0;
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL first_not_early got %0b want 0", t_valid); end
    step();
    update = 1'b0;
    exp_retire = 1;
    tests++; if (t_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %0b want 1", t_valid); end
    tests++; if (t_pc !== 32'h8000_0000) begin fails++; $display("FAIL first_pc got %h want 80000000", t_pc); end
    tests++; if (t_instr !== 32'h0000_0093) begin fails++; $display("FAIL first_instr got %h want 00000093", t_instr); end
    tests++; if (t_rd !== 5'd1) begin fails++; $display("FAIL first_rd got %0d want 1", t_rd); end
    tests++; if (t_wb !== 1'b1) begin fails++; $display("FAIL first_wb got %0b want 1", t_wb); end
    tests++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL first_retire got %0d want 1", retire_cnt); end
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL first_drained got %0b want 0", t_valid); end
  endtask

  task automatic test_x0();
    update = 1'b1; pc = 32'h8000_0004; instr = 32'h0000_0013; reg_addr = 5'd0; reg_data = 32'hDEAD_BEEF;
    step();
    update = 1'b0;
    exp_retire++;
    tests++; if (t_rd_data !== 32'h0) begin fails++; $display("FAIL x0_data got %h want 00000000", t_rd_data); end
    tests++; if (t_wb !== 1'b0) begin fails++; $display("FAIL x0_wb got %0b want 0", t_wb); end
    tests++; if (t_pc !== 32'h8000_0004) begin fails++; $display("FAIL x0_pc got %h want 80000004", t_pc); end
    // Non-x0 data passes through unchanged
    t_ready = 1'b1; update = 1'b1; pc = 32'h8000_0008; reg_addr = 5'd7; reg_data = 32'hCAFE_F00D;
    step();
    update = 1'b0;
    exp_retire++;
    tests++; if (t_rd_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL rd_data got %h want cafef00d", t_rd_data); end
    step();
    t_ready = 1'b0;
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL x0_level got %0d want 0", level); end
  endtask

  task automatic test_backpressure();
    t_ready = 1'b0; reg_addr = 5'd2; instr = 32'h0;
    for (int i = 0; i < 20; i++) begin
      update = 1'b1; pc = i; reg_data = 32'h100 + i;
      step();
    end
    update = 1'b0;
    exp_retire += 20;
    exp_drop = 4;
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL bp_level got %0d want 16", level); end
    tests++; if (drop_cnt !== 32'd4) begin fails++; $display("FAIL bp_drop got %0d want 4", drop_cnt); end
    tests++; if (retire_cnt !== exp_retire) begin fails++; $display("FAIL bp_retire got %0d want %0d", retire_cnt, exp_retire); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow got %0b want 1", overflow); end
    step();
    tests++; if (t_pc !== 32'd0) begin fails++; $display("FAIL bp_head_stable got %h want 0", t_pc); end
    t_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (t_valid !== 1'b1 || t_pc !== i || t_rd_data !== 32'h100 + i) begin
        fails++; $display("FAIL bp_drain%0d got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                          i, t_valid, t_pc, t_rd_data, i, 32'h100 + i);
      end
      step();
    end
    t_ready = 1'b0;
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %0b want 0", t_valid); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_pushpop();
    t_ready = 1'b0; reg_addr = 5'd4;
    for (int i = 0; i < 16; i++) begin
      update = 1'b1; pc = 32'h100 + i; reg_data = i;
      step();
    end
    exp_retire += 16;
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL fpp_full got %0d want 16", level); end
    update = 1'b1; t_ready = 1'b1; pc = 32'h200;
    step();
    update = 1'b0;
    exp_retire++;
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL fpp_level got %0d want 16", level); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL fpp_drop got %0d want %0d", drop_cnt, exp_drop); end
    tests++; if (retire_cnt !== exp_retire) begin fails++; $display("FAIL fpp_retire got %0d want %0d", retire_cnt, exp_retire); end
    for (int i = 1; i < 16; i++) begin
      tests++;
      if (t_pc !== 32'h100 + i) begin fails++; $display("FAIL fpp_pop%0d got %h want %h", i, t_pc, 32'h100 + i); end
      step();
    end
    tests++; if (t_pc !== 32'h200) begin fails++; $display("FAIL fpp_new got %h want 00000200", t_pc); end
    step();
    t_ready = 1'b0;
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL fpp_empty got %0d want 0", level); end
  endtask

  task automatic test_stream();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_retire = 0; exp_drop = 0;
    tests++; if (drop_cnt !== 32'd0) begin fails++; $display("FAIL st_clr_drop got %0d want 0", drop_cnt); end
    t_ready = 1'b1; reg_addr = 5'd9;
    for (int i = 0; i < 100; i++) begin
      update = 1'b1; pc = 32'h1000 + i; reg_data = 32'hA000 + i;
      step();
      tests++;
      if (level > 5'd1 || t_valid !== 1'b1 || t_pc !== 32'h1000 + i || t_rd_data !== 32'hA000 + i) begin
        fails++; $display("FAIL st_cycle%0d got lvl=%0d v=%0b pc=%h want lvl<=1 v=1 pc=%h",
                          i, level, t_valid, t_pc, 32'h1000 + i);
      end
    end
    update = 1'b0;
    exp_retire += 100;
    step();
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL st_level got %0d want 0", level); end
    tests++; if (drop_cnt !== 32'd0) begin fails++; $display("FAIL st_drop got %0d want 0", drop_cnt); end
    tests++; if (retire_cnt !== exp_retire) begin fails++; $display("FAIL st_retire got %0d want %0d", retire_cnt, exp_retire); end
    t_ready = 1'b0;
  endtask

  task automatic test_clr();
    t_ready = 1'b0; reg_addr = 5'd5;
    for (int i = 0; i < 17; i++) begin
      update = 1'b1; pc = 32'h300 + i; reg_data = i;
      step();
    end
    update = 1'b0;
    t_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    t_ready = 1'b0;
    tests++; if (level !== 5'd5) begin fails++; $display("FAIL clr_pre_level got %0d want 5", level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL clr_pre_ovf got %0b want 1", overflow); end
    tests++; if (drop_cnt !== 32'd1) begin fails++; $display("FAIL clr_pre_drop got %0d want 1", drop_cnt); end
    clr = 1'b1; update = 1'b1; t_ready = 1'b1; pc = 32'h400;
    step();
    clr = 1'b0; update = 1'b0; t_ready = 1'b0;
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL clr_level got %0d want 0", level); end
    tests++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL clr_retire got %0d want 0", retire_cnt); end
    tests++; if (drop_cnt !== 32'd0) begin fails++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL clr_valid got %0b want 0", t_valid); end
    tests++; if (t_pc !== 32'd0) begin fails++; $display("FAIL clr_pc got %h want 0", t_pc); end
    update = 1'b1; pc = 32'h500;
    step();
    update = 1'b0;
    tests++; if (retire_cnt !== 32'd1 || level !== 5'd1 || t_pc !== 32'h500) begin
      fails++; $display("FAIL clr_resume got rc=%0d lvl=%0d pc=%h want rc=1 lvl=1 pc=00000500", retire_cnt, level, t_pc);
    end
  endtask

  initial begin
    tests = 0; fails = 0; exp_retire = 0; exp_drop = 0;
    rst = 1'b1; update = 1'b0; pc = '0; instr = '0; reg_addr = '0; reg_data = '0;
    clr = 1'b0; t_ready = 1'b0;
    #2;
    test_reset();
    test_x0();
    test_backpressure();
    test_full_pushpop();
    test_stream();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
